// File: rtl/seq_det_sched.sv
// seq_det_sched: round-robin shared run-of-ones detector with per-channel context (optional SEQ_DET_SCHED_STATS_EN match counters)
module seq_det_sched #(
  parameter int NCH = 4,
  parameter int RUN_LEN = 4,
  localparam int CW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] din,
  input  logic [NCH-1:0] flush,
  output logic [NCH-1:0] gnt,
  output logic           match_vld,
  output logic [CW-1:0]  match_ch,
  output logic           busy
`ifdef SEQ_DET_SCHED_STATS_EN
  ,
  input  logic [CW-1:0]  stat_sel,
  output logic [15:0]    stat_cnt
`endif
);
  localparam int CNTW = $clog2(RUN_LEN);
  localparam logic [CNTW-1:0] CMAX = CNTW'(RUN_LEN - 1);
  logic [CW-1:0]   ptr, ptr_nx, gidx;
  logic [CNTW-1:0] cnt [NCH];
  logic [CNTW-1:0] cnt_nx [NCH];
  logic [NCH-1:0]  hitv;
  logic            hit, found, busy_nx;
  int              idx;
  // pick the first requester at or after ptr, wrapping; nothing is granted in reset
  always_comb begin
    gnt = '0;
    gidx = '0;
    found = 1'b0;
    idx = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = (int'(ptr) + i) % NCH;
      if (reset && !found && req[idx]) begin
        found = 1'b1;
        gnt[idx] = 1'b1;
        gidx = CW'(idx);
      end
    end
    ptr_nx = !found ? ptr : (int'(gidx) == NCH - 1) ? '0 : gidx + 1'b1;
  end
  // flush clears first, then the granted bit is applied; a full counter saturates and matches again
  always_comb begin
    hitv = '0;
    busy_nx = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      cnt_nx[i] = flush[i] ? CNTW'(gnt[i] & din[i]) :
                  !gnt[i]  ? cnt[i] :
                  !din[i]  ? '0 :
                  (cnt[i] == CMAX) ? CMAX : cnt[i] + 1'b1;
      hitv[i] = gnt[i] & din[i] & ~flush[i] & (cnt[i] == CMAX);
      busy_nx = busy_nx | (cnt_nx[i] != '0);
    end
    hit = |hitv;
  end
  // contexts, pointer and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
      cnt <= '{default: '0};
      match_vld <= 1'b0;
      match_ch <= '0;
      busy <= 1'b0;
    end else begin
      ptr <= ptr_nx;
      cnt <= cnt_nx;
      match_vld <= hit;
      match_ch <= hit ? gidx : '0;
      busy <= busy_nx;
    end
  end
`ifdef SEQ_DET_SCHED_STATS_EN
  logic [15:0] mcnt [NCH];
  // saturating per-channel match counters with registered readback
  always_ff @(posedge clk) begin
    if (!reset) begin
      mcnt <= '{default: '0};
      stat_cnt <= '0;
    end else begin
      for (int i = 0; i < NCH; i++)
        mcnt[i] <= flush[i] ? '0 : (hitv[i] && mcnt[i] != 16'hFFFF) ? mcnt[i] + 16'd1 : mcnt[i];
      stat_cnt <= (int'(stat_sel) < NCH) ? mcnt[stat_sel] : '0;
    end
  end
`endif
endmodule

// File: tb/tb_seq_det_sched.sv
// tb_seq_det_sched: directed bench with a run-length reference model checked every cycle
module tb_seq_det_sched;
  localparam int NCH = 4;
  localparam int RUN_LEN = 4;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] req, din, flush, gnt;
  logic match_vld, busy;
  logic [1:0] match_ch;
`ifdef SEQ_DET_SCHED_STATS_EN
  logic [1:0] stat_sel;
  logic [15:0] stat_cnt;
`endif
  int total = 0;
  int bad = 0;
  int run [4] = '{default: 0};
  int mptr = 0;
  int e_vld = 0;
  int e_ch = 0;
  int e_busy = 0;
  logic [6:0] bits;

  seq_det_sched #(.NCH(NCH), .RUN_LEN(RUN_LEN)) dut (
    .clk(clk), .reset(reset), .req(req), .din(din), .flush(flush),
    .gnt(gnt), .match_vld(match_vld), .match_ch(match_ch), .busy(busy)
`ifdef SEQ_DET_SCHED_STATS_EN
    , .stat_sel(stat_sel), .stat_cnt(stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < NCH; i++)
      if (r[(p + i) % NCH]) return (p + i) % NCH;
    return -1;
  endfunction

  // reference model: unbounded run lengths, a match whenever a 1 extends a run to RUN_LEN or more
  always @(posedge clk) begin
    int k;
    if (!reset) begin
      run = '{default: 0};
      mptr = 0;
      e_vld = 0;
      e_ch = 0;
      e_busy = 0;
    end else begin
      k = pick(req, mptr);
      e_vld = 0;
      for (int i = 0; i < NCH; i++) if (flush[i]) run[i] = 0;
      if (k >= 0) begin
        if (din[k]) begin
          if (run[k] >= RUN_LEN - 1) begin
            e_vld = 1;
            e_ch = k;
          end
          run[k]++;
        end else run[k] = 0;
        mptr = (k + 1) % NCH;
      end
      e_busy = 0;
      for (int i = 0; i < NCH; i++) if (run[i] != 0) e_busy = 1;
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    int k;
    k = pick(req, mptr);
    chk("m_gnt", int'(gnt), (reset && k >= 0) ? (1 << k) : 0);
    chk("m_match_vld", int'(match_vld), e_vld);
    if (e_vld != 0) chk("m_match_ch", int'(match_ch), e_ch);
    chk("m_busy", int'(busy), e_busy);
  end

  initial begin
    reset = 1'b0;
    req = 4'b1111;
    din = 4'b0000;
    flush = 4'b0000;
`ifdef SEQ_DET_SCHED_STATS_EN
    stat_sel = 2'd1;
`endif
    @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_vld", int'(match_vld), 0);
    repeat (2) cyc();
    cyc();
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("fair_gnt", int'(gnt), 1 << (c % 4));
      cyc();
    end
    req = 4'b0100;
    bits = 7'b1011111;
    for (int j = 0; j < 7; j++) begin
      din = {1'b0, bits[j], 2'b00};
      @(negedge clk);
      chk("run_gnt", int'(gnt), 4);
      chk("run_vld", int'(match_vld), (j == 4 || j == 5) ? 1 : 0);
      if (j == 4 || j == 5) chk("run_ch", int'(match_ch), 2);
      cyc();
    end
    req = 4'b0000;
    din = 4'b0000;
    flush = 4'b0100;
    @(negedge clk);
    chk("run_end_vld", int'(match_vld), 0);
    chk("run_end_busy", int'(busy), 1);
    cyc();
    flush = 4'b0000;
    req = 4'b0011;
    for (int c = 0; c < 12; c++) begin
      din = {2'b00, ((c / 2) % 2 == 0), 1'b1};
      @(negedge clk);
      chk("il_gnt", int'(gnt), (c % 2 == 0) ? 1 : 2);
      chk("il_vld", int'(match_vld), (c >= 7 && c % 2 == 1) ? 1 : 0);
      if (match_vld) chk("il_ch", int'(match_ch), 0);
      cyc();
    end
    req = 4'b1000;
    din = 4'b1000;
    repeat (3) cyc();
    flush = 4'b1000;
    @(negedge clk);
    chk("fl_gnt", int'(gnt), 8);
    cyc();
    flush = 4'b0000;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("fl_vld", int'(match_vld), 0);
      cyc();
    end
    req = 4'b0000;
    @(negedge clk);
    chk("fl_match_vld", int'(match_vld), 1);
    chk("fl_match_ch", int'(match_ch), 3);
    cyc();
    req = 4'b1010;
    din = 4'b0000;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_gnt", int'(gnt), 0);
    cyc();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_first_gnt", int'(gnt), 2);
    cyc();
`ifdef SEQ_DET_SCHED_STATS_EN
    req = 4'b0010;
    din = 4'b0010;
    repeat (8) cyc();
    req = 4'b0000;
    cyc();
    @(negedge clk);
    chk("stat_cnt5", int'(stat_cnt), 5);
    cyc();
    flush = 4'b0010;
    cyc();
    flush = 4'b0000;
    cyc();
    @(negedge clk);
    chk("stat_cnt0", int'(stat_cnt), 0);
    cyc();
`endif
    req = 4'b0000;
    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_det_sched.md
# seq_det_sched

Round-robin scheduler that shares one run-of-ones detector among NCH serial bit-stream requesters. Each requester offers one bit at a time and holds it until granted. The block keeps a private detector context per channel, so interleaving never mixes streams. It sits between the serial input ports and the event logic that consumes per-channel match pulses.

## Interface

Parameters:
- NCH, default 4: number of requesting channels; at least 2.
- RUN_LEN, default 4: number of consecutive 1s that raises a match; at least 2.
- CW, default $clog2(NCH): channel-index width; derived, not overridden.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- req  in  NCH  req[i] = channel i offers bit din[i]; held until gnt[i].
- din  in  NCH  offered bit per channel; stable while req[i] is high.
- flush  in  NCH  flush[i] clears channel i's context; single-cycle pulse.
- gnt  out  NCH  one-hot grant, combinational; the granted bit is consumed this cycle.
- match_vld  out  1  registered one-cycle match pulse.
- match_ch  out  CW  channel index for match_vld; valid only while match_vld = 1.
- busy  out  1  registered; 1 while any channel context is nonzero.

## Operation

- **Per-channel context:** run counter cnt[i] in the range 0..RUN_LEN-1.
- **Round-robin pointer ptr:** CW bits, reset to 0.
- **Arbitration:**
  - gnt = first set bit of req, searching circularly from ptr.
  - gnt = 0 when req = 0.
  - On a grant to channel k, ptr ← (k+1) mod NCH. Otherwise ptr holds.
- **Processing of the granted bit b, channel k:**
  - b = 0: cnt[k] ← 0, no match.
  - b = 1 and cnt[k] < RUN_LEN-1: cnt[k] ← cnt[k]+1, no match.
  - b = 1 and cnt[k] = RUN_LEN-1: match; cnt[k] holds at RUN_LEN-1, so detection overlaps and every further 1 matches again.
- **Flush:**
  - flush[i] sets cnt[i] ← 0 and takes precedence over the context update.
  - If channel i is granted in the same cycle, its bit is evaluated against the cleared context. The result is cnt = b, and no match unless RUN_LEN = 1, which the parameter range excludes.
  - flush never blocks or alters gnt.
- **Ungranted channels:** contexts unchanged.
- **busy:** OR of (cnt[i] ≠ 0) over all i, after the current cycle's update.
- **Reset (reset = 0):**
  - All cnt = 0, ptr = 0.
  - Outputs: match_vld = 0, match_ch = 0, busy = 0.
  - gnt is forced to 0 while reset = 0, regardless of req.
- **Reset mid-stream:** all partial runs are discarded. The first grant after release goes to the lowest requesting index.

## Timing

- Grant: combinational, same cycle as req (cycle T).
- Context update at the clk edge ending cycle T.
- match_vld/match_ch: asserted in cycle T+1 for exactly one cycle. Back-to-back matches (any channels) give consecutive match_vld pulses.
- Throughput: one bit per cycle total. A channel with continuous req is served at least once every NCH cycles.
- No combinational path from din to any output. gnt depends only on req, ptr and reset.

## Configuration

- **SEQ_DET_SCHED_STATS_EN defined:** adds the following ports.
  - stat_sel  in  CW: selects the channel whose count is read.
  - stat_cnt  out  16: registered, one-cycle latency; the match count of channel stat_sel.
  - Per-channel 16-bit match counters increment on each match and saturate at 0xFFFF.
  - Counters are cleared by reset and by flush[i].
- **Not defined:** ports and counters are absent. All other behaviour is identical.

## Test plan

- **Reset:** reset = 0 for 3 cycles with req = 4'b1111.
  - gnt = 0, match_vld = 0, busy = 0.
  - After release, first gnt = 4'b0001.
- **Fairness:** req = 4'b1111 held for 8 cycles -> gnt sequence 0001, 0010, 0100, 1000, repeating; no channel is skipped.
- **Single-channel run:** RUN_LEN = 4; channel 2 alone sends 1,1,1,1,1,0,1.
  - match_vld pulses one cycle after the 4th and after the 5th bit, with match_ch = 2.
  - No further match; busy = 1 after the final bit.
- **Interleave isolation:** channels 0 and 1 both request; channel 0 sends all 1s, channel 1 alternates 1,0.
  - Matches occur only with match_ch = 0, first after channel 0's 4th granted bit.
- **Flush collision:** channel 3 has cnt = 3; flush[3] = 1 in the same cycle as a granted bit 1.
  - No match; cnt[3] = 1.
  - Three more 1s are required before the next match.
- **Stats (with SEQ_DET_SCHED_STATS_EN):** 5 matches on channel 1, then stat_sel = 1 -> stat_cnt = 5 next cycle; after flush[1] -> stat_cnt = 0.
